// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin arbiter sharing the FIFO write port among NUM_REQ requesters
// Optional burst lock compiled in with FIFO_WR_ARB_BURST_LOCK_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                     wr_clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic                     fifo_full,
    input  logic                     fifo_write_error,
    output logic                     fifo_write_en,
    output logic [WIDTH-1:0]         fifo_write_data,
    output logic [ID_W-1:0]          grant_id,
    output logic                     grant_valid,
    output logic                     err_sticky
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_LOCK  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] grant_id_q, grant_id_d;
    logic            err_sticky_q, err_sticky_d;

    logic [ID_W-1:0] rr_win;
    logic            rr_found;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] win_inc;
    logic            locked;
    logic            serve;
    logic            beat;

`ifdef FIFO_WR_ARB_BURST_LOCK_EN
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
`endif

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int idx;
        idx      = 0;
        rr_found = 1'b0;
        rr_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!rr_found && req_valid[ID_W'(idx)]) begin
                rr_found = 1'b1;
                rr_win   = ID_W'(idx);
            end
        end
    end

    // A held burst keeps the grant only while its owner still presents data;
    // otherwise the same cycle falls back to plain round-robin.
    always_comb begin
        locked  = (state_q == ST_LOCK) && req_valid[grant_id_q];
        win     = locked ? grant_id_q : rr_win;
        serve   = ~rst & (locked | rr_found);
        beat    = serve & ~fifo_full;
        win_inc = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
    end

    always_comb begin
        fifo_write_en   = beat;
        grant_valid     = serve;
        fifo_write_data = '0;
        req_ready       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (serve && (win == ID_W'(i))) begin
                fifo_write_data = req_data[i*WIDTH +: WIDTH];
            end
        end
        if (beat) begin
            req_ready[win] = 1'b1;
        end
        grant_id   = rst ? '0 : grant_id_q;
        err_sticky = ~rst & err_sticky_q;
    end

    always_comb begin
        rr_ptr_d     = beat ? win_inc : rr_ptr_q;
        grant_id_d   = beat ? win : grant_id_q;
        err_sticky_d = err_sticky_q | fifo_write_error;
        state_d      = (|req_valid) ? ST_SERVE : ST_IDLE;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
        beat_cnt_d = '0;
        if (locked && !beat) begin
            // Stalled by fifo_full: keep the lock, do not count.
            state_d    = ST_LOCK;
            beat_cnt_d = beat_cnt_q;
        end else if (locked) begin
            if (int'(beat_cnt_q) + 1 < BURST_LEN) begin
                state_d    = ST_LOCK;
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end else if (beat && (BURST_LEN > 1)) begin
            state_d    = ST_LOCK;
            beat_cnt_d = CNT_W'(1);
        end
`endif
    end

    always_ff @(posedge wr_clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            err_sticky_q <= err_sticky_d;
        end
    end

`ifdef FIFO_WR_ARB_BURST_LOCK_EN
    always_ff @(posedge wr_clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
// Burst-lock expectations follow FIFO_WR_ARB_BURST_LOCK_EN.
module tb_fifo_wr_arbiter;
    localparam int N  = 4;
    localparam int W  = 8;
    localparam int BL = 4;
    localparam int IW = 2;
`ifdef FIFO_WR_ARB_BURST_LOCK_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic          wr_clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          fifo_full;
    logic          fifo_write_error;
    logic          fifo_write_en;
    logic [W-1:0]  fifo_write_data;
    logic [IW-1:0] grant_id;
    logic          grant_valid;
    logic          err_sticky;

    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .BURST_LEN(BL)) dut (
        .wr_clk(wr_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_write_error(fifo_write_error),
        .fifo_write_en(fifo_write_en), .fifo_write_data(fifo_write_data),
        .grant_id(grant_id), .grant_valid(grant_valid), .err_sticky(err_sticky)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct { int cyc; int id; int data; } beat_t;
    typedef struct { int cyc; int wr; int gv; int gid; int err; int data; int ready; } stat_t;

    beat_t beat_q[$];
    stat_t stat_q[$];
    int vectors = 0;
    int miscompares = 0;
    int cur_cyc = 0;
    int cyc = 0;
    int dut_wr_cnt = 0;

    // Reference state: pointer, last winner, burst owner/count, sticky error, sources, FIFO fill.
    int m_ptr = 0, m_gid = 0, m_g = 0, m_cnt = 0, m_err = 0, fcnt = 0;
    bit m_lock = 1'b0;
    int src_cnt [N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cur_cyc, act, exp);
        end
    endtask

    function automatic int data_of(input int i);
        return (i << 6) | (src_cnt[i] & 63);
    endfunction

    function automatic int ready_idx(input logic [N-1:0] r);
        int idx = -1;
        for (int i = 0; i < N; i++) if (r[i] === 1'b1) idx = i;
        return idx;
    endfunction

    task automatic drive_cycle(input bit r, input logic [N-1:0] v, input bit f, input bit e);
        int owner;
        stat_t s;
        beat_t b;
        rst = r; req_valid = v; fifo_full = f; fifo_write_error = e;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = W'(data_of(i));
        s.cyc = cyc; s.wr = 0; s.gv = 0; s.data = 0; s.ready = 0; s.gid = 0; s.err = 0;
        if (r) begin
            m_ptr = 0; m_gid = 0; m_lock = 1'b0; m_cnt = 0; m_err = 0;
        end else begin
            s.gid = m_gid;
            s.err = m_err;
            owner = -1;
            if (BURST && m_lock && v[m_g]) begin
                owner = m_g;
            end else begin
                m_lock = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (owner < 0 && v[(m_ptr + k) % N]) owner = (m_ptr + k) % N;
                end
            end
            if (owner >= 0) begin
                s.gv = 1;
                s.data = data_of(owner);
                if (!f) begin
                    s.wr = 1;
                    s.ready = 1 << owner;
                    b.cyc = cyc; b.id = owner; b.data = data_of(owner);
                    beat_q.push_back(b);
                    src_cnt[owner]++;
                    fcnt++;
                    m_ptr = (owner + 1) % N;
                    m_gid = owner;
                    if (BURST) begin
                        if (m_lock) m_cnt++;
                        else begin m_lock = 1'b1; m_g = owner; m_cnt = 1; end
                        if (m_cnt >= BL) m_lock = 1'b0;
                    end
                end
            end
            m_err = m_err | int'(e);
        end
        stat_q.push_back(s);
        @(posedge wr_clk);
        #1;
        cyc++;
    endtask

    // Monitor: one status entry per cycle, one beat entry per observed write.
    initial begin
        stat_t s;
        beat_t b;
        forever begin
            @(negedge wr_clk);
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                cur_cyc = s.cyc;
                chk("write_en", 32'(fifo_write_en), s.wr);
                chk("grant_valid", 32'(grant_valid), s.gv);
                chk("grant_id", 32'(grant_id), s.gid);
                chk("err_sticky", 32'(err_sticky), s.err);
                chk("req_ready", 32'(req_ready), s.ready);
                chk("write_data", 32'(fifo_write_data), s.data);
                if (fifo_write_en === 1'b1) begin
                    dut_wr_cnt++;
                    if (beat_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_write cycle %0d: got write of %0h expected none", cur_cyc, fifo_write_data);
                    end else begin
                        b = beat_q.pop_front();
                        chk("beat_src", ready_idx(req_ready), b.id);
                        chk("beat_data", 32'(fifo_write_data), b.data);
                    end
                end
            end
        end
    end

    initial begin
        int w0;
        bit r, f, e;
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) src_cnt[i] = 0;
        rst = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0; fifo_write_error = 1'b0;
        @(posedge wr_clk);
        #1;

        // Reset held with every requester valid, then free-running round-robin.
        repeat (2) drive_cycle(1, 4'hF, 0, 0);
        repeat (12) drive_cycle(0, 4'hF, 0, 0);

        // Single requester with a 3-cycle full pulse mid-stream.
        w0 = dut_wr_cnt;
        for (int c = 0; c < 12; c++) drive_cycle(0, 4'b0100, (c >= 4 && c < 7), 0);
        cur_cyc = cyc;
        chk("full_pulse_writes", dut_wr_cnt - w0, 9);

        // Fill a 16-deep FIFO that is never read.
        fcnt = 0;
        w0 = dut_wr_cnt;
        for (int c = 0; c < 24; c++) drive_cycle(0, 4'hF, (fcnt >= 16), 0);
        cur_cyc = cyc;
        chk("fill_writes", dut_wr_cnt - w0, 16);

        // Two contenders, then requester 0 drops out two beats into a grant.
        drive_cycle(1, 4'hF, 0, 0);
        repeat (10) drive_cycle(0, 4'b0011, 0, 0);
        repeat (4) drive_cycle(0, 4'b0010, 0, 0);
        repeat (6) drive_cycle(0, 4'b0011, 0, 0);

        // One-cycle write error, then reset in the middle of traffic.
        drive_cycle(0, 4'hF, 0, 1);
        repeat (5) drive_cycle(0, 4'hF, 0, 0);
        drive_cycle(1, 4'hF, 0, 0);
        repeat (4) drive_cycle(0, 4'hF, 0, 0);

        for (int c = 0; c < 400; c++) begin
            r = ($urandom_range(99) < 2);
            v = N'($urandom_range(15));
            f = ($urandom_range(99) < 20);
            e = ($urandom_range(99) < 1);
            drive_cycle(r, v, f, e);
        end

        @(negedge wr_clk);
        #1;
        cur_cyc = cyc;
        chk("stat_q_drain", stat_q.size(), 0);
        chk("beat_q_drain", beat_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
